pwm_profile_controller: RTL

Multi-channel servo/ESC pulse generator that plays a programmable, multi-step pulse-width profile on a start trigger, then returns to neutral. It supersedes the single-channel fixed-profile arm driver: profile step count, pulse widths, step durations, frame period and channel count are all parametrised or port-driven. It sits between the control FSM (start/abort) and the board's PWM pins.

---
 rtl/pwm_pkg.sv | 30 +++
 rtl/pwm_channel.sv | 39 +++
 rtl/pwm_profile_controller.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM profile controller: sequencer states,
// 50 MHz timing defaults and the pulse-width clamp.
package pwm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

  localparam int PERIOD_20MS = 1000000;
  localparam int PW_NEUTRAL  = 75000;
  localparam int PW_MIN      = 50000;
  localparam int PW_MAX      = 100000;

  // Wide enough for any practical counter width; callers cast in and out.
  localparam int CLAMP_W = 64;
  typedef logic [CLAMP_W-1:0] clamp_t;

  function automatic clamp_t clampPw(input clamp_t pw, input clamp_t lo, input clamp_t hi);
    clamp_t r;
    r = pw;
    if (pw < lo) begin
      r = lo;
    end else if (pw > hi) begin
      r = hi;
    end
    return r;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: latches its target width at the frame boundary and
// drives a registered compare against the shared frame counter.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int NEUTRAL = PW_NEUTRAL
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CNT_W-1:0] frame_cnt,
  input  logic             frame_end,
  input  logic [CNT_W-1:0] target_pw,
  output logic             signal
);

  logic [CNT_W-1:0] pw_l_q, pw_l_d;
  logic             signal_q, signal_d;

  // Width only changes on the last clock of a frame, so a pulse in flight
  // is never cut short or stretched.
  always_comb begin
    pw_l_d   = frame_end ? target_pw : pw_l_q;
    signal_d = (frame_cnt < pw_l_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pw_l_q   <= CNT_W'(NEUTRAL);
      signal_q <= 1'b0;
    end else begin
      pw_l_q   <= pw_l_d;
      signal_q <= signal_d;
    end
  end

  assign signal = signal_q;

endmodule

// File: rtl/pwm_profile_controller.sv
// Multi-channel servo/ESC driver: plays a STEPS-long pulse-width profile on
// start, then falls back to NEUTRAL. All channels share one frame counter.
module pwm_profile_controller
  import pwm_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 32,
  parameter int PERIOD   = PERIOD_20MS,
  parameter int NEUTRAL  = PW_NEUTRAL,
  parameter int MIN_PW   = PW_MIN,
  parameter int MAX_PW   = PW_MAX,
  parameter int STEPS    = 3,
  localparam int IDX_W   = (STEPS > 1) ? $clog2(STEPS) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [STEPS*CNT_W-1:0] step_pw,
  input  logic [STEPS*CNT_W-1:0] step_len,
  input  logic [CHANNELS-1:0]    ch_enable,
  output logic [CHANNELS-1:0]    signal,
  output logic                   busy,
  output logic                   done,
  output logic [IDX_W-1:0]       step_idx
);

  localparam logic [CNT_W-1:0] PERIOD_M1 = CNT_W'(PERIOD - 1);
  localparam logic [IDX_W-1:0] LAST_STEP = IDX_W'(STEPS - 1);

  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             frame_end;

  seq_state_e       state_q;
  logic [IDX_W-1:0] step_idx_q;
  logic [CNT_W-1:0] step_cnt_q;
  logic             busy_q, done_q;

  logic [CNT_W-1:0] cur_pw, cur_len, cur_len_m1, run_pw;
  logic             step_last_clk;

  always_comb begin
    frame_end   = (frame_cnt_q == PERIOD_M1);
    frame_cnt_d = frame_end ? '0 : frame_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // A zero duration is treated as one clock so every step is visited.
  always_comb begin
    cur_pw  = '0;
    cur_len = '0;
    for (int k = 0; k < STEPS; k++) begin
      if (step_idx_q == IDX_W'(k)) begin
        cur_pw  = step_pw[k*CNT_W +: CNT_W];
        cur_len = step_len[k*CNT_W +: CNT_W];
      end
    end
    cur_len_m1    = (cur_len == '0) ? '0 : cur_len - CNT_W'(1);
    step_last_clk = (step_cnt_q >= cur_len_m1);
    run_pw        = CNT_W'(clampPw(clamp_t'(cur_pw), clamp_t'(MIN_PW), clamp_t'(MAX_PW)));
  end

  // Durations are in clocks, not frames: a step shorter than a frame can
  // finish without ever being latched onto an output.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      step_idx_q <= '0;
      step_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_q    <= RUN;
            step_idx_q <= '0;
            step_cnt_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state_q    <= IDLE;
            step_idx_q <= '0;
            step_cnt_q <= '0;
            busy_q     <= 1'b0;
          end else if (step_last_clk) begin
            step_cnt_q <= '0;
            if (step_idx_q < LAST_STEP) begin
              step_idx_q <= step_idx_q + IDX_W'(1);
            end else begin
              state_q    <= IDLE;
              step_idx_q <= '0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end
          end else begin
            step_cnt_q <= step_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [CNT_W-1:0] target_pw;

    assign target_pw = ((state_q == RUN) && ch_enable[c]) ? run_pw : CNT_W'(NEUTRAL);

    pwm_channel #(
      .CNT_W  (CNT_W),
      .NEUTRAL(NEUTRAL)
    ) u_ch (
      .clock    (clock),
      .reset    (reset),
      .frame_cnt(frame_cnt_q),
      .frame_end(frame_end),
      .target_pw(target_pw),
      .signal   (signal[c])
    );
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign step_idx = step_idx_q;

endmodule
